// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: shift-add multiply, restoring divide, mthi/mtlo, flush.
// Optional macro MULDIV_FAST_MUL_EN replaces the 32-cycle multiply with a single-cycle 32x32 product.
module muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        mul_start,
    input  logic        div_start,
    input  logic        op_signed,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        hilo_read,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  count_r;
    logic [63:0] acc_r;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [31:0] opnd_r;      // multiplicand or divisor magnitude
    logic        op_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        dbz_r;

    logic        start_mul_s;
    logic        start_div_s;
    logic        dbz_s;
    logic        step_s;
    logic        finish_s;
    logic        write_hi_s;
    logic        write_lo_s;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] sum_s;
    logic [63:0] mul_step_s;
    logic [32:0] shifted_s;
    logic [32:0] trial_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    assign busy  = (state_r != IDLE);
    assign stall = busy & (hilo_read | mul_start | div_start | mthi | mtlo);

    // Operand sign and magnitude for signed operations.
    always_comb begin
        a_neg_s = op_signed & operand_a[31];
        b_neg_s = op_signed & operand_b[31];
        if (a_neg_s) begin
            a_mag_s = 32'd0 - operand_a;
        end else begin
            a_mag_s = operand_a;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - operand_b;
        end else begin
            b_mag_s = operand_b;
        end
    end

    // One shift-add multiply iteration and one restoring-divide iteration.
    always_comb begin
        sum_s     = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
        shifted_s = {acc_r[63:32], acc_r[31]};
        trial_s   = shifted_s - {1'b0, opnd_r};
        if (acc_r[0]) begin
            mul_step_s = {sum_s, acc_r[31:1]};
        end else begin
            mul_step_s = {1'b0, acc_r[63:1]};
        end
        if (!trial_s[32]) begin
            div_step_s = {trial_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            div_step_s = {shifted_s[31:0], acc_r[30:0], 1'b0};
        end
    end

    // Next-state and control strobes; flush aborts everything.
    always_comb begin
        state_s     = state_r;
        start_mul_s = 1'b0;
        start_div_s = 1'b0;
        dbz_s       = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        write_hi_s  = 1'b0;
        write_lo_s  = 1'b0;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mul_start) begin
                        start_mul_s = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state_s     = FINISH;
`else
                        state_s     = RUN;
`endif
                    end else if (div_start) begin
                        start_div_s = 1'b1;
                        if (operand_b == 32'd0) begin
                            dbz_s   = 1'b1;
                            state_s = FINISH;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        write_hi_s = mthi;
                        write_lo_s = mtlo;
                    end
                end
                RUN: begin
                    step_s = 1'b1;
                    if (count_r == 5'd0) begin
                        state_s = FINISH;
                    end else begin
                        state_s = RUN;
                    end
                end
                FINISH: begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Final sign correction of the magnitude result.
    always_comb begin
        prod_s = 64'd0 - acc_r;
        quo_s  = 32'd0 - acc_r[31:0];
        rem_s  = 32'd0 - acc_r[63:32];
        if (dbz_r) begin
            res_hi_s = acc_r[63:32];
            res_lo_s = acc_r[31:0];
        end else if (op_div_r) begin
            res_hi_s = neg_r_r ? rem_s : acc_r[63:32];
            res_lo_s = neg_q_r ? quo_s : acc_r[31:0];
        end else begin
            res_hi_s = neg_q_r ? prod_s[63:32] : acc_r[63:32];
            res_lo_s = neg_q_r ? prod_s[31:0]  : acc_r[31:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration counter and arithmetic accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r  <= 5'd0;
            acc_r    <= 64'd0;
            opnd_r   <= 32'd0;
            op_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (start_mul_s) begin
            count_r  <= 5'd31;
`ifdef MULDIV_FAST_MUL_EN
            acc_r    <= {32'd0, a_mag_s} * {32'd0, b_mag_s};
`else
            acc_r    <= {32'd0, b_mag_s};
`endif
            opnd_r   <= a_mag_s;
            op_div_r <= 1'b0;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (start_div_s) begin
            count_r  <= 5'd31;
            opnd_r   <= b_mag_s;
            op_div_r <= 1'b1;
            dbz_r    <= dbz_s;
            if (dbz_s) begin
                acc_r   <= {operand_a, 32'hFFFF_FFFF};
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else begin
                acc_r   <= {32'd0, a_mag_s};
                neg_q_r <= a_neg_s ^ b_neg_s;
                neg_r_r <= a_neg_s;
            end
        end else if (step_s) begin
            acc_r   <= op_div_r ? div_step_s : mul_step_s;
            count_r <= (count_r == 5'd0) ? 5'd0 : count_r - 5'd1;
        end
    end

    // HI/LO architectural registers and the registered completion pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi          <= 32'd0;
            lo          <= 32'd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (finish_s) begin
                hi <= res_hi_s;
                lo <= res_lo_s;
            end else begin
                if (write_hi_s) begin
                    hi <= operand_a;
                end
                if (write_lo_s) begin
                    lo <= operand_a;
                end
            end
            done        <= finish_s;
            div_by_zero <= finish_s & dbz_r;
        end
    end

endmodule
